// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops one word per frame from the TX FIFO and serialises it LSB first.
// Define UART_TX_PARITY_EN to insert one even-parity bit between the data and stop bits.
module uart_tx_fifo_drain #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT * 2);
  localparam int IDX_W = $clog2(DATA_SIZE + 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_SIZE - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     baud_reg, baud_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_SIZE-1:0] shift_reg, shift_next;
  logic                 tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg, parity_next;
`endif
  logic                 pop;
  logic                 baud_done;

  assign baud_done = (baud_reg == BAUD_LAST);
  // Pop only from IDLE, so a frame can never consume more than one word.
  assign pop       = (state_reg == S_IDLE) && tx_enable && !fifo_empty && !reset;
  assign fifo_read = pop;
  assign busy      = (state_reg != S_IDLE);
  assign tx        = tx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    tx_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    // One shared baud counter; wrapping to zero on every boundary keeps bits drift-free.
    if (state_reg != S_IDLE) begin
      baud_next = baud_done ? '0 : baud_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (pop) begin
          shift_next  = fifo_data;
          baud_next   = '0;
          idx_next    = '0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^fifo_data;
`endif
          state_next  = S_START;
        end
      end
      S_START: begin
        if (baud_done) state_next = S_DATA;
      end
      S_DATA: begin
        if (baud_done) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == DATA_LAST) begin
            idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          if (idx_reg == STOP_LAST) begin
            idx_next   = '0;
            state_next = S_IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // tx is registered from the upcoming state so the line changes with the state itself.
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = parity_next;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain at CLKS_PER_BIT=4, DATA_SIZE=8, STOP_BITS=1.
// Follows UART_TX_PARITY_EN so the same bench covers both builds.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F    = (1 + DW + PB + SB) * CPB;
  localparam int LOGN = 512;

  logic          clk;
  logic          reset;
  logic          tx_enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_read;
  logic          tx;
  logic          busy;

  int vectors;
  int miscompares;

  logic [DW-1:0] q[$];
  logic          pop_pending;
  logic          rst_req;
  logic          en_req;
  logic          tx_log   [LOGN];
  logic          busy_log [LOGN];
  logic          rd_log   [LOGN];
  int            ncyc;

  uart_tx_fifo_drain #(
    .DATA_SIZE   (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_enable (tx_enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: inputs change on the falling edge, outputs are logged 1 ns later.
  task automatic step();
    logic [DW-1:0] tmp;
    @(negedge clk);
    if (pop_pending) begin
      if (q.size() > 0) tmp = q.pop_front();
      pop_pending = 1'b0;
    end
    reset      = rst_req;
    tx_enable  = en_req;
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? '0 : q[0];
    #1;
    if (ncyc < LOGN) begin
      tx_log[ncyc]   = tx;
      busy_log[ncyc] = busy;
      rd_log[ncyc]   = fifo_read;
    end
    if (fifo_read && !reset) pop_pending = 1'b1;
    ncyc++;
  endtask

  task automatic test_reset();
    ncyc = 0; rst_req = 1'b1; en_req = 1'b0; q.delete();
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0 || rd_log[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d: tx=%b busy=%b fifo_read=%b, required 1 0 0",
                 i, tx_log[i], busy_log[i], rd_log[i]);
      end
    end
    rst_req = 1'b0; ncyc = 0;
    repeat (100) step();
    for (int i = 0; i < 100; i++) begin
      vectors++;
      if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0 || rd_log[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_empty cyc=%0d: tx=%b busy=%b fifo_read=%b, required 1 0 0",
                 i, tx_log[i], busy_log[i], rd_log[i]);
      end
    end
  endtask

  task automatic test_single_word();
    logic [11:0] fv;
    int pops, busy_cnt;
    ncyc = 0; en_req = 1'b1; q.push_back(8'h55);
    repeat (F + 10) step();
    // 0x55 frame: start 0, data 1,0,1,0,1,0,1,0, [parity 0], stop 1
    fv = (PB == 1) ? 12'b1110_1010_1010 : 12'b1111_0101_0101 << 0;
    if (PB == 0) fv = 12'b1110_1010_1010 >> 1 | 12'b1000_0000_0000;
    fv = '1; fv[0] = 1'b0; fv[8:1] = 8'h55;
    if (PB == 1) fv[9] = 1'b0;
    pops = 0; busy_cnt = 0;
    for (int i = 0; i < F + 10; i++) begin
      if (rd_log[i] === 1'b1) pops++;
      if (busy_log[i] === 1'b1) busy_cnt++;
    end
    vectors++;
    if (rd_log[0] !== 1'b1 || pops != 1) begin
      miscompares++;
      $display("FAIL single_pop: first_read=%b pops=%0d, required 1 1", rd_log[0], pops);
    end
    vectors++;
    if (busy_cnt != F) begin
      miscompares++;
      $display("FAIL single_busy_len: busy cycles=%0d, required %0d", busy_cnt, F);
    end
    for (int k = 0; k < F; k++) begin
      vectors++;
      if (tx_log[1 + k] !== fv[k / CPB] || busy_log[1 + k] !== 1'b1) begin
        miscompares++;
        $display("FAIL single_frame_0x55 cyc=%0d: tx=%b busy=%b, required %b 1",
                 1 + k, tx_log[1 + k], busy_log[1 + k], fv[k / CPB]);
      end
    end
    vectors++;
    if (tx_log[F + 1] !== 1'b1 || busy_log[F + 1] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after_frame: tx=%b busy=%b, required 1 0", tx_log[F + 1], busy_log[F + 1]);
    end
  endtask

  task automatic test_parity();
    logic [DW-1:0] words [2];
    logic          par   [2];
    logic          exp_bit;
    int            busy_cnt;
    words[0] = 8'h07; par[0] = 1'b1;
    words[1] = 8'h55; par[1] = 1'b0;
    en_req = 1'b1;
    for (int w = 0; w < 2; w++) begin
      ncyc = 0; q.push_back(words[w]);
      repeat (F + 5) step();
      // Slot after the last data bit: parity when compiled in, else the stop bit.
      exp_bit = (PB == 1) ? par[w] : 1'b1;
      for (int k = 0; k < CPB; k++) begin
        vectors++;
        if (tx_log[1 + CPB * (DW + 1) + k] !== exp_bit) begin
          miscompares++;
          $display("FAIL parity_bit word=%h cyc=%0d: tx=%b, required %b",
                   words[w], 1 + CPB * (DW + 1) + k, tx_log[1 + CPB * (DW + 1) + k], exp_bit);
        end
      end
      busy_cnt = 0;
      for (int i = 0; i < F + 5; i++) if (busy_log[i] === 1'b1) busy_cnt++;
      vectors++;
      if (busy_cnt != F) begin
        miscompares++;
        $display("FAIL parity_frame_len word=%h: busy cycles=%0d, required %0d", words[w], busy_cnt, F);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_w [2];
    logic [DW-1:0] got;
    int p [2];
    int n, s;
    exp_w[0] = 8'hA3; exp_w[1] = 8'h0F;
    ncyc = 0; en_req = 1'b1;
    q.push_back(8'hA3); q.push_back(8'h0F);
    repeat (2 * F + 10) step();
    n = 0; p[0] = -1; p[1] = -1;
    for (int i = 0; i < 2 * F + 10; i++) begin
      if (rd_log[i] === 1'b1) begin
        if (n < 2) p[n] = i;
        n++;
      end
    end
    vectors++;
    if (n != 2 || p[0] != 0 || p[1] != F + 1) begin
      miscompares++;
      $display("FAIL b2b_pops: count=%0d first=%0d second=%0d, required 2 0 %0d", n, p[0], p[1], F + 1);
    end
    for (int f = 0; f < 2; f++) begin
      s = (f == 0) ? 1 : F + 2;
      vectors++;
      if (tx_log[s - 1] !== 1'b1 || tx_log[s] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_start_edge frame=%0d: tx=%b%b, required 10", f, tx_log[s - 1], tx_log[s]);
      end
      for (int b = 0; b < DW; b++) got[b] = tx_log[s + CPB * (b + 1) + CPB / 2];
      vectors++;
      if (got !== exp_w[f]) begin
        miscompares++;
        $display("FAIL b2b_decode frame=%0d: got %h, required %h", f, got, exp_w[f]);
      end
      vectors++;
      if (tx_log[s + CPB * (DW + PB + 1) + CPB / 2] !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_stop frame=%0d: tx=%b, required 1", f, tx_log[s + CPB * (DW + PB + 1) + CPB / 2]);
      end
    end
  endtask

  task automatic test_enable();
    logic [DW-1:0] got;
    int pops;
    ncyc = 0; en_req = 1'b0; q.delete();
    q.push_back(8'h3C); q.push_back(8'h91);
    repeat (20) step();
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (rd_log[i] !== 1'b0 || busy_log[i] !== 1'b0 || tx_log[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL enable_low cyc=%0d: fifo_read=%b busy=%b tx=%b, required 0 0 1",
                 i, rd_log[i], busy_log[i], tx_log[i]);
      end
    end
    en_req = 1'b1;
    step();
    vectors++;
    if (rd_log[20] !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_rise_pop: fifo_read=%b, required 1", rd_log[20]);
    end
    repeat (12) step();
    en_req = 1'b0;
    repeat (F + 20) step();
    pops = 0;
    for (int i = 0; i < ncyc; i++) if (rd_log[i] === 1'b1) pops++;
    vectors++;
    if (pops != 1 || q.size() != 1) begin
      miscompares++;
      $display("FAIL enable_drop_pops: pops=%0d left=%0d, required 1 1", pops, q.size());
    end
    for (int b = 0; b < DW; b++) got[b] = tx_log[21 + CPB * (b + 1) + CPB / 2];
    vectors++;
    if (got !== 8'h3C) begin
      miscompares++;
      $display("FAIL enable_drop_frame: got %h, required 3c", got);
    end
    vectors++;
    if (busy_log[ncyc - 1] !== 1'b0 || tx_log[ncyc - 1] !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_drop_idle: busy=%b tx=%b, required 0 1", busy_log[ncyc - 1], tx_log[ncyc - 1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] got;
    int pops;
    ncyc = 0; en_req = 1'b1; q.delete();
    q.push_back(8'h91); q.push_back(8'hE1);
    repeat (18) step();
    // Index 17 lies in data bit 3 of 0x91, which is 0.
    vectors++;
    if (rd_log[0] !== 1'b1 || tx_log[17] !== 1'b0 || busy_log[17] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre: read=%b tx=%b busy=%b, required 1 0 1", rd_log[0], tx_log[17], busy_log[17]);
    end
    rst_req = 1'b1;
    repeat (2) step();
    for (int i = 18; i < 20; i++) begin
      vectors++;
      if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0 || rd_log[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_forced cyc=%0d: tx=%b busy=%b fifo_read=%b, required 1 0 0",
                 i, tx_log[i], busy_log[i], rd_log[i]);
      end
    end
    rst_req = 1'b0;
    repeat (F + 5) step();
    vectors++;
    if (rd_log[20] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_repop: fifo_read=%b, required 1", rd_log[20]);
    end
    for (int b = 0; b < DW; b++) got[b] = tx_log[21 + CPB * (b + 1) + CPB / 2];
    vectors++;
    if (got !== 8'hE1) begin
      miscompares++;
      $display("FAIL rst_mid_next_word: got %h, required e1", got);
    end
    pops = 0;
    for (int i = 0; i < ncyc; i++) if (rd_log[i] === 1'b1) pops++;
    vectors++;
    if (pops != 2 || q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_mid_pop_count: pops=%0d left=%0d, required 2 0", pops, q.size());
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; pop_pending = 1'b0;
    rst_req = 1'b1; en_req = 1'b0; ncyc = 0;
    reset = 1'b1; tx_enable = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    test_reset();
    test_single_word();
    test_parity();
    test_back_to_back();
    test_enable();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
